mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/byte_ram.sv | 38 +++
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared access-size and dump-FSM encodings for the memory stage
package mem_stage_pkg;

    // Access size encodings carried on i_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Debug dump sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } dump_state_t;

    // True when the access size cannot be served at this byte offset.
    // Encoding 2'b11 is reserved and always treated as misaligned.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - word-organised RAM with byte-enable write port and two async read ports
//
// Ports:
//   clk        write clock, rising edge
//   wr_be      per-lane write enables, lane i covers wr_data[8i+7:8i]
//   wr_addr    word index written
//   wr_data    write data
//   rd_addr_a  pipeline read word index -> rd_data_a (combinational)
//   rd_addr_b  debug read word index    -> rd_data_b (combinational)
// Contents are not reset.
module byte_ram #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic [3:0]        wr_be,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [31:0]       rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [31:0]       rd_data_b
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // Reads see the contents from before the current edge's write
    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: byte-addressed loads/stores plus a debug memory dump
//
// Ports:
//   i_clk, i_reset        clock (rising edge), asynchronous active-low reset
//   i_enable, i_flush     pipeline advance, bubble insert (flush dominates)
//   i_alu_result          byte address / ALU result passed through to WB
//   i_operand_b           store data
//   i_mem_read/write      load / store request
//   i_size, i_unsigned    access size, zero-extend loads
//   i_reg_write, i_mem_to_reg, i_rd   WB control passed through
//   i_dbg_dump            start a full memory dump
//   o_*_W                 registered WB-stage outputs
//   o_dbg_*               dump stream: data, word address, valid, last, busy
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 5,
    parameter int REG_W      = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic [DATA_W-1:0]     i_alu_result,
    input  logic [DATA_W-1:0]     i_operand_b,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic                  i_reg_write,
    input  logic                  i_mem_to_reg,
    input  logic [REG_W-1:0]      i_rd,
    input  logic                  i_dbg_dump,
    output logic [DATA_W-1:0]     o_alu_result_W,
    output logic [DATA_W-1:0]     o_read_data_W,
    output logic                  o_reg_write_W,
    output logic                  o_mem_to_reg_W,
    output logic [REG_W-1:0]      o_rd_W,
    output logic                  o_misaligned_W,
    output logic [DATA_W-1:0]     o_dbg_data,
    output logic [MEM_ADDR_W-1:0] o_dbg_addr,
    output logic                  o_dbg_valid,
    output logic                  o_dbg_last,
    output logic                  o_dbg_busy
);

    logic [MEM_ADDR_W-1:0] word_idx;
    logic [1:0]            byte_off;
    logic                  misaligned;
    logic                  mem_we;
    logic [3:0]            lane_be;
    logic [3:0]            ram_be;
    logic [DATA_W-1:0]     lane_wdata;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     rd_shifted;
    logic [DATA_W-1:0]     load_data;
    logic [DATA_W-1:0]     dbg_word;
    logic [MEM_ADDR_W-1:0] dump_cnt;
    logic                  dump_at_end;
    dump_state_t           state;
    dump_state_t           state_nxt;

    // Upper address bits are dropped so accesses wrap modulo the depth
    assign word_idx   = i_alu_result[MEM_ADDR_W+1:2];
    assign byte_off   = i_alu_result[1:0];
    assign misaligned = (i_mem_read | i_mem_write) & size_misaligned(i_size, byte_off);
    assign mem_we     = i_mem_write & i_enable & ~i_flush & ~misaligned;

    // Store data is replicated across lanes so only the enables pick the position
    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = i_operand_b;
        case (i_size)
            SZ_BYTE: begin
                lane_be    = 4'b0001 << byte_off;
                lane_wdata = {4{i_operand_b[7:0]}};
            end
            SZ_HALF: begin
                lane_be    = byte_off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{i_operand_b[15:0]}};
            end
            SZ_WORD: lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    end

    assign ram_be = mem_we ? lane_be : 4'b0000;

    byte_ram #(
        .ADDR_W(MEM_ADDR_W)
    ) u_ram (
        .clk       (i_clk),
        .wr_be     (ram_be),
        .wr_addr   (word_idx),
        .wr_data   (lane_wdata),
        .rd_addr_a (word_idx),
        .rd_data_a (rd_word),
        .rd_addr_b (dump_cnt),
        .rd_data_b (dbg_word)
    );

    // Move the addressed byte/half down to bit 0, then extend
    assign rd_shifted = rd_word >> {byte_off, 3'b000};

    always_comb begin
        load_data = '0;
        case (i_size)
            SZ_BYTE: load_data = {{24{rd_shifted[7] & ~i_unsigned}}, rd_shifted[7:0]};
            SZ_HALF: load_data = {{16{rd_shifted[15] & ~i_unsigned}}, rd_shifted[15:0]};
            SZ_WORD: load_data = rd_word;
            default: load_data = '0;
        endcase
        // A simultaneous store takes priority and the load returns zero
        if (!i_mem_read || i_mem_write || misaligned) begin
            load_data = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_alu_result_W <= '0;
            o_read_data_W  <= '0;
            o_reg_write_W  <= 1'b0;
            o_mem_to_reg_W <= 1'b0;
            o_rd_W         <= '0;
            o_misaligned_W <= 1'b0;
        end else if (i_flush) begin
            o_alu_result_W <= '0;
            o_read_data_W  <= '0;
            o_reg_write_W  <= 1'b0;
            o_mem_to_reg_W <= 1'b0;
            o_rd_W         <= '0;
            o_misaligned_W <= 1'b0;
        end else if (i_enable) begin
            o_alu_result_W <= i_alu_result;
            o_read_data_W  <= load_data;
            o_reg_write_W  <= i_reg_write;
            o_mem_to_reg_W <= i_mem_to_reg;
            o_rd_W         <= i_rd;
            o_misaligned_W <= misaligned;
        end
    end

    assign dump_at_end = (dump_cnt == {MEM_ADDR_W{1'b1}});

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_dbg_dump) state_nxt = ST_DUMP;
            ST_DUMP: if (dump_at_end) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Dump data/address hold their last value once the dump ends
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            dump_cnt    <= '0;
            o_dbg_data  <= '0;
            o_dbg_addr  <= '0;
            o_dbg_valid <= 1'b0;
            o_dbg_last  <= 1'b0;
        end else if (state == ST_DUMP) begin
            o_dbg_data  <= dbg_word;
            o_dbg_addr  <= dump_cnt;
            o_dbg_valid <= 1'b1;
            o_dbg_last  <= dump_at_end;
            dump_cnt    <= dump_cnt + 1'b1;
        end else begin
            o_dbg_valid <= 1'b0;
            o_dbg_last  <= 1'b0;
            if (i_dbg_dump) begin
                dump_cnt <= '0;
            end
        end
    end

    assign o_dbg_busy = (state == ST_DUMP);

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a byte-array reference model
module tb_mem_stage;

    localparam int NB = 128;

    logic        i_clk;
    logic        i_reset;
    logic        i_enable;
    logic        i_flush;
    logic [31:0] i_alu_result;
    logic [31:0] i_operand_b;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic        i_reg_write;
    logic        i_mem_to_reg;
    logic [4:0]  i_rd;
    logic        i_dbg_dump;
    logic [31:0] o_alu_result_W;
    logic [31:0] o_read_data_W;
    logic        o_reg_write_W;
    logic        o_mem_to_reg_W;
    logic [4:0]  o_rd_W;
    logic        o_misaligned_W;
    logic [31:0] o_dbg_data;
    logic [4:0]  o_dbg_addr;
    logic        o_dbg_valid;
    logic        o_dbg_last;
    logic        o_dbg_busy;

    mem_stage #(.DATA_W(32), .MEM_ADDR_W(5), .REG_W(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
        .i_alu_result(i_alu_result), .i_operand_b(i_operand_b),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
        .i_rd(i_rd), .i_dbg_dump(i_dbg_dump),
        .o_alu_result_W(o_alu_result_W), .o_read_data_W(o_read_data_W),
        .o_reg_write_W(o_reg_write_W), .o_mem_to_reg_W(o_mem_to_reg_W), .o_rd_W(o_rd_W),
        .o_misaligned_W(o_misaligned_W), .o_dbg_data(o_dbg_data), .o_dbg_addr(o_dbg_addr),
        .o_dbg_valid(o_dbg_valid), .o_dbg_last(o_dbg_last), .o_dbg_busy(o_dbg_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Reference model: flat little-endian byte memory plus expected outputs
    logic [7:0]  mm [NB];
    logic [31:0] e_alu, e_rdata, e_dd;
    logic        e_rw, e_m2r, e_mis, e_dv, e_dl, e_busy;
    logic [4:0]  e_rd, e_da;
    int          d_idx = 0;
    int          d_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int w);
        return {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]};
    endfunction

    task automatic model_reset();
        e_alu = 0; e_rdata = 0; e_rw = 0; e_m2r = 0; e_rd = 0; e_mis = 0;
        e_dd = 0; e_da = 0; e_dv = 0; e_dl = 0; e_busy = 0;
        d_idx = 0; d_left = 0;
    endtask

    // Predict the effect of the coming edge from current inputs, then advance one cycle
    task automatic tick();
        int unsigned ba, off;
        logic [31:0] w, sh, v, rdv, n_alu, n_rdata, n_dd;
        logic mis, n_rw, n_m2r, n_mis, n_dv, n_dl;
        logic [4:0] n_rd, n_da;
        ba  = int'(i_alu_result[6:0]);
        off = ba % 4;
        w   = word_of(int'(ba / 4));
        mis = (i_mem_read || i_mem_write) &&
              ((i_size == 2'd1 && off % 2 == 1) || (i_size == 2'd2 && off != 0) || i_size == 2'd3);
        sh  = w >> (8 * off);
        case (i_size)
            2'd0: v = i_unsigned ? (sh & 32'hFF) : 32'($signed(sh[7:0]));
            2'd1: v = i_unsigned ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
            default: v = w;
        endcase
        rdv = (i_mem_read && !i_mem_write && !mis) ? v : 32'd0;

        n_alu = e_alu; n_rdata = e_rdata; n_rw = e_rw; n_m2r = e_m2r; n_rd = e_rd; n_mis = e_mis;
        if (i_flush) begin
            n_alu = 0; n_rdata = 0; n_rw = 0; n_m2r = 0; n_rd = 0; n_mis = 0;
        end else if (i_enable) begin
            n_alu = i_alu_result; n_rdata = rdv; n_rw = i_reg_write;
            n_m2r = i_mem_to_reg; n_rd = i_rd; n_mis = mis;
        end

        n_dd = e_dd; n_da = e_da; n_dv = 0; n_dl = 0;
        if (d_left > 0) begin
            n_dd = word_of(d_idx);
            n_da = 5'(d_idx);
            n_dv = 1;
            n_dl = (d_idx == 31);
            d_idx++;
            d_left--;
        end else if (i_dbg_dump) begin
            d_idx = 0;
            d_left = 32;
        end

        if (i_mem_write && i_enable && !i_flush && !mis) begin
            mm[ba] = i_operand_b[7:0];
            if (i_size != 2'd0) mm[ba + 1] = i_operand_b[15:8];
            if (i_size == 2'd2) begin
                mm[ba + 2] = i_operand_b[23:16];
                mm[ba + 3] = i_operand_b[31:24];
            end
        end

        @(posedge i_clk);
        #1;
        e_alu = n_alu; e_rdata = n_rdata; e_rw = n_rw; e_m2r = n_m2r; e_rd = n_rd; e_mis = n_mis;
        e_dd = n_dd; e_da = n_da; e_dv = n_dv; e_dl = n_dl; e_busy = (d_left > 0);
    endtask

    always @(negedge i_clk) begin
        if (check_en) begin
            chk("alu_result_W", o_alu_result_W, e_alu);
            chk("read_data_W", o_read_data_W, e_rdata);
            chk("reg_write_W", 32'(o_reg_write_W), 32'(e_rw));
            chk("mem_to_reg_W", 32'(o_mem_to_reg_W), 32'(e_m2r));
            chk("rd_W", 32'(o_rd_W), 32'(e_rd));
            chk("misaligned_W", 32'(o_misaligned_W), 32'(e_mis));
            chk("dbg_data", o_dbg_data, e_dd);
            chk("dbg_addr", 32'(o_dbg_addr), 32'(e_da));
            chk("dbg_valid", 32'(o_dbg_valid), 32'(e_dv));
            chk("dbg_last", 32'(o_dbg_last), 32'(e_dl));
            chk("dbg_busy", 32'(o_dbg_busy), 32'(e_busy));
        end
    end

    task automatic set_idle();
        i_enable = 1; i_flush = 0; i_mem_read = 0; i_mem_write = 0; i_size = 2'd2;
        i_unsigned = 0; i_reg_write = 0; i_mem_to_reg = 0; i_rd = 0; i_dbg_dump = 0;
        i_alu_result = 0; i_operand_b = 0;
    endtask

    task automatic op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] addr, input logic [31:0] data);
        set_idle();
        i_mem_read = rd; i_mem_write = wr; i_size = sz; i_unsigned = uns;
        i_alu_result = addr; i_operand_b = data;
        i_reg_write = rd; i_mem_to_reg = rd; i_rd = addr[4:0];
        tick();
    endtask

    task automatic dump_run(input bit pattern);
        int cnt, lastcnt, lastaddr;
        cnt = 0; lastcnt = 0; lastaddr = -1;
        set_idle();
        i_dbg_dump = 1;
        tick();
        i_dbg_dump = 0;
        repeat (34) begin
            tick();
            if (o_dbg_valid) begin
                chk("dump_addr_seq", 32'(o_dbg_addr), 32'(cnt));
                if (pattern) chk("dump_data_pattern", o_dbg_data, 32'(cnt) * 32'h11);
                if (o_dbg_last) begin
                    lastcnt++;
                    lastaddr = int'(o_dbg_addr);
                end
                cnt++;
            end
        end
        chk("dump_valid_count", 32'(cnt), 32'd32);
        chk("dump_last_count", 32'(lastcnt), 32'd1);
        chk("dump_last_addr", 32'(lastaddr), 32'd31);
    endtask

    initial begin
        bit found;
        set_idle();
        i_reset = 0;
        model_reset();
        @(posedge i_clk);
        #1;
        chk("reset_alu", o_alu_result_W, 32'd0);
        chk("reset_rdata", o_read_data_W, 32'd0);
        chk("reset_dbg_valid", 32'(o_dbg_valid), 32'd0);
        chk("reset_dbg_busy", 32'(o_dbg_busy), 32'd0);
        i_reset = 1;
        check_en = 1;

        for (int k = 0; k < 32; k++) op(0, 1, 2'd2, 0, 32'(k * 4), 32'(k) * 32'h11);
        dump_run(1);

        op(0, 1, 2'd2, 0, 32'h04, 32'h8899AABB);
        op(1, 0, 2'd0, 0, 32'h05, 0);
        chk("lb_0x05", o_read_data_W, 32'hFFFFFFAA);
        op(1, 0, 2'd0, 1, 32'h07, 0);
        chk("lbu_0x07", o_read_data_W, 32'h00000088);
        op(1, 0, 2'd1, 0, 32'h06, 0);
        chk("lh_0x06", o_read_data_W, 32'hFFFF8899);

        op(0, 1, 2'd2, 0, 32'h08, 32'h0);
        op(0, 1, 2'd0, 0, 32'h0A, 32'h7F);
        op(1, 0, 2'd2, 0, 32'h08, 0);
        chk("sb_then_lw", o_read_data_W, 32'h007F0000);

        op(0, 1, 2'd1, 0, 32'h03, 32'hBEEF);
        chk("sh_mis_flag", 32'(o_misaligned_W), 32'd1);
        op(1, 0, 2'd2, 0, 32'h02, 0);
        chk("lw_mis_flag", 32'(o_misaligned_W), 32'd1);
        chk("lw_mis_data", o_read_data_W, 32'd0);
        op(1, 0, 2'd2, 0, 32'h00, 0);
        chk("mis_store_blocked", o_read_data_W, 32'd0);

        op(1, 0, 2'd2, 0, 32'h0C, 0);
        chk("lw_0x0c", o_read_data_W, 32'h33);
        set_idle();
        i_enable = 0; i_mem_write = 1; i_alu_result = 32'h0C; i_operand_b = 32'hDEADBEEF;
        i_reg_write = 1; i_rd = 5'd9;
        tick();
        chk("stall_hold_data", o_read_data_W, 32'h33);
        chk("stall_hold_alu", o_alu_result_W, 32'h0C);
        op(1, 0, 2'd2, 0, 32'h0C, 0);
        chk("stall_no_write", o_read_data_W, 32'h33);
        set_idle();
        i_flush = 1; i_mem_read = 1; i_reg_write = 1; i_alu_result = 32'h0C; i_rd = 5'd7;
        tick();
        chk("flush_alu", o_alu_result_W, 32'd0);
        chk("flush_rdata", o_read_data_W, 32'd0);
        chk("flush_reg_write", 32'(o_reg_write_W), 32'd0);
        chk("flush_rd", 32'(o_rd_W), 32'd0);

        set_idle();
        i_dbg_dump = 1;
        tick();
        i_dbg_dump = 0;
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick();
            if (o_dbg_valid && o_dbg_addr == 5'd10) found = 1;
        end
        chk("reach_dump_addr10", 32'(found), 32'd1);
        check_en = 0;
        #2;
        i_reset = 0;
        #1;
        chk("async_rst_valid", 32'(o_dbg_valid), 32'd0);
        chk("async_rst_busy", 32'(o_dbg_busy), 32'd0);
        chk("async_rst_addr", 32'(o_dbg_addr), 32'd0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1;
        check_en = 1;
        dump_run(0);

        for (int n = 0; n < 500; n++) begin
            i_enable     = ($urandom_range(0, 99) < 85);
            i_flush      = ($urandom_range(0, 99) < 8);
            i_mem_read   = 1'($urandom_range(0, 1));
            i_mem_write  = 1'($urandom_range(0, 1));
            i_size       = 2'($urandom_range(0, 3));
            i_unsigned   = 1'($urandom_range(0, 1));
            i_alu_result = $urandom_range(0, 255) | ($urandom_range(0, 1) << 20);
            i_operand_b  = $urandom;
            i_reg_write  = 1'($urandom_range(0, 1));
            i_mem_to_reg = 1'($urandom_range(0, 1));
            i_rd         = 5'($urandom_range(0, 31));
            i_dbg_dump   = ($urandom_range(0, 99) < 4);
            tick();
        end

        set_idle();
        repeat (2) tick();
        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
